snax_hwpe_periph_regfile: RTL and testbench

// HWPE peripheral-port slave behind the SNAX unbuffered periph controller.

---
 rtl/snax_hwpe_periph_regfile.sv | 88 ++++++++
 tb/tb_snax_hwpe_periph_regfile.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/snax_hwpe_periph_regfile.sv
// snax_hwpe_periph_regfile: HWPE periph-port job register file with start/busy/done tracking.
module snax_hwpe_periph_regfile #(
  parameter int NumCfgRegs = 4,
  parameter int IdWidth    = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    periph_req_i,
  output logic                    periph_gnt_o,
  input  logic [31:0]             periph_add_i,
  input  logic                    periph_wen_i,
  input  logic [3:0]              periph_be_i,
  input  logic [31:0]             periph_data_i,
  input  logic [IdWidth-1:0]      periph_id_i,
  output logic [31:0]             periph_r_data_o,
  output logic                    periph_r_valid_o,
  output logic [IdWidth-1:0]      periph_r_id_o,
  output logic                    start_o,
  input  logic                    done_i,
  output logic [32*NumCfgRegs-1:0] cfg_o,
  output logic                    busy_o,
  output logic                    irq_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [31:0] cfg [NumCfgRegs];
  logic [31:0] perf, rdata;
  logic [5:0] idx;
  logic in_range, rd, wr, enter, busy, done_sticky, irq_en;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^periph_add_i[1:0];
  assign idx = periph_add_i[7:2];
  assign in_range = periph_add_i[31:8] == '0 && {1'b0, idx} < 7'(4 + NumCfgRegs);
  assign periph_gnt_o = periph_req_i & ~periph_r_valid_o;
  assign rd = periph_gnt_o & periph_wen_i;
  assign wr = periph_gnt_o & ~periph_wen_i & in_range;
  assign busy = state == RUN;
  assign enter = !busy && wr && idx == 6'd0;
  assign busy_o = busy;
  assign irq_o = done_sticky & irq_en;
  for (genvar k = 0; k < NumCfgRegs; k++) begin : g_cfg
    assign cfg_o[32*k +: 32] = cfg[k];
  end
  always_comb state_next = !busy ? (enter ? RUN : IDLE) : (done_i ? IDLE : RUN);
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    rdata = '0;
    if (in_range) begin
      rdata = idx == 6'd1 ? {30'b0, done_sticky, busy} :
              idx == 6'd2 ? {31'b0, irq_en} :
              idx == 6'd3 ? perf : '0;
      for (int k = 0; k < NumCfgRegs; k++)
        if (idx == 6'(4 + k)) rdata = cfg[k];
    end
  end
  // A done pulse outranks a same-cycle W1C so a completion is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_o <= 1'b0;
      done_sticky <= 1'b0;
      irq_en <= 1'b0;
      perf <= '0;
      periph_r_valid_o <= 1'b0;
      periph_r_data_o <= '0;
      periph_r_id_o <= '0;
      for (int k = 0; k < NumCfgRegs; k++) cfg[k] <= '0;
    end else begin
      start_o <= enter;
      periph_r_valid_o <= rd;
      if (rd) begin
        periph_r_data_o <= rdata;
        periph_r_id_o <= periph_id_i;
      end
      perf <= enter ? '0 : (busy && perf != '1) ? perf + 32'd1 : perf;
      done_sticky <= enter ? 1'b0 :
                     (busy && done_i) ? 1'b1 :
                     (wr && idx == 6'd1 && periph_data_i[1]) ? 1'b0 : done_sticky;
      if (wr && idx == 6'd2) irq_en <= periph_data_i[0];
      for (int k = 0; k < NumCfgRegs; k++)
        if (wr && !busy && idx == 6'(4 + k))
          for (int b = 0; b < 4; b++)
            if (periph_be_i[b]) cfg[k][8*b +: 8] <= periph_data_i[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// tb_snax_hwpe_periph_regfile: scoreboard bench with a transaction-level register-file model.
module tb_snax_hwpe_periph_regfile;
  localparam int N = 4;
  localparam int IW = 5;
  logic clk = 1'b0;
  logic rst, req, wen, done, gnt, r_valid, start, busy, irq;
  logic [31:0] add, wdata, r_data;
  logic [3:0] be;
  logic [IW-1:0] id, r_id;
  logic [32*N-1:0] cfg_flat;
  always #5 clk = ~clk;
  snax_hwpe_periph_regfile #(.NumCfgRegs(N), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_i(rst), .periph_req_i(req), .periph_gnt_o(gnt),
    .periph_add_i(add), .periph_wen_i(wen), .periph_be_i(be), .periph_data_i(wdata),
    .periph_id_i(id), .periph_r_data_o(r_data), .periph_r_valid_o(r_valid),
    .periph_r_id_o(r_id), .start_o(start), .done_i(done), .cfg_o(cfg_flat),
    .busy_o(busy), .irq_o(irq)
  );
  typedef struct packed {logic [31:0] data; logic [IW-1:0] id;} rsp_t;
  rsp_t sb[$];
  rsp_t exp_rsp;
  int n_vec = 0, n_err = 0;
  bit armed = 1'b0;
  logic [31:0] m_cfg [N];
  logic [31:0] m_perf = '0;
  logic m_busy = 0, m_sticky = 0, m_irq = 0, m_start = 0, m_rvalid = 0;
  logic [32*N-1:0] m_flat;
  function automatic logic [31:0] model_read(input logic [31:0] a);
    int i;
    i = int'(a[7:2]);
    if (a[31:8] != 0 || i >= 4 + N) return 32'd0;
    case (i)
      0: return 32'd0;
      1: return {30'b0, m_sticky, m_busy};
      2: return {31'b0, m_irq};
      3: return m_perf;
      default: return m_cfg[i-4];
    endcase
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // One bus cycle: drive, let the edge sample it, then advance the model by what that edge did.
  task automatic step(input logic r, input logic q, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic [IW-1:0] i,
                      input logic dn);
    logic g, inr, pre_busy, set_s, clr_s;
    int x;
    rst = r; req = q; wen = w; add = a; wdata = d; be = b; id = i; done = dn;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_sticky = 0; m_irq = 0; m_start = 0; m_rvalid = 0; m_perf = '0;
      for (int k = 0; k < N; k++) m_cfg[k] = '0;
      sb.delete();
    end else begin
      g = q & ~m_rvalid;
      x = int'(a[7:2]);
      inr = a[31:8] == 0 && x < 4 + N;
      pre_busy = m_busy;
      set_s = 0;
      clr_s = 0;
      if (g && w) sb.push_back('{data: model_read(a), id: i});
      m_rvalid = g && w;
      m_start = 0;
      if (pre_busy) begin
        if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
        if (dn) begin m_busy = 0; set_s = 1; end
      end
      if (g && !w && inr) begin
        if (x == 0 && !pre_busy) begin m_busy = 1; m_start = 1; m_perf = '0; m_sticky = 0; end
        if (x == 1 && d[1]) clr_s = 1;
        if (x == 2) m_irq = d[0];
        if (x >= 4 && !pre_busy)
          for (int k = 0; k < 4; k++) if (b[k]) m_cfg[x-4][8*k +: 8] = d[8*k +: 8];
      end
      if (set_s) m_sticky = 1;
      else if (clr_s) m_sticky = 0;
    end
    #1;
  endtask
  task automatic idle(input int n, input logic dn);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, dn);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    step(0, 1, 0, a, d, b, 0, 0);
  endtask
  task automatic rd(input logic [31:0] a, input logic [IW-1:0] i);
    step(0, 1, 1, a, 0, 0, i, 0);
    idle(1, 0);
  endtask
  always @(negedge clk) if (armed) begin
    for (int k = 0; k < N; k++) m_flat[32*k +: 32] = m_cfg[k];
    chk("gnt", gnt, req & ~m_rvalid);
    chk("r_valid", r_valid, m_rvalid);
    chk("busy", busy, m_busy);
    chk("start", start, m_start);
    chk("irq", irq, m_sticky & m_irq);
    chk("cfg", cfg_flat, m_flat);
    if (r_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got data %h id %h, none required", r_data, r_id);
      end else begin
        exp_rsp = sb.pop_front();
        chk("r_data", r_data, exp_rsp.data);
        chk("r_id", r_id, exp_rsp.id);
      end
    end
  end
  initial begin
    for (int k = 0; k < N; k++) m_cfg[k] = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    armed = 1'b1;
    idle(1, 0);
    wr(32'h10, 32'hA5A5_1234, 4'hF);
    rd(32'h10, 5'd3);
    wr(32'h14, 32'hFFFF_FFFF, 4'b0010);
    rd(32'h14, 5'd4);
    wr(32'h0, 32'h0, 4'h0);
    idle(9, 0);
    idle(1, 1);
    idle(2, 0);
    rd(32'h4, 5'd1);
    rd(32'hC, 5'd2);
    wr(32'h8, 32'h1, 4'h0);
    wr(32'h0, 32'h0, 4'h0);
    idle(3, 0);
    idle(1, 1);
    idle(2, 0);
    wr(32'h4, 32'h2, 4'h0);
    idle(2, 0);
    wr(32'h0, 32'h0, 4'h0);
    idle(1, 0);
    wr(32'h0, 32'h0, 4'h0);
    wr(32'h10, 32'h1, 4'hF);
    rd(32'h10, 5'd7);
    idle(1, 1);
    idle(1, 0);
    step(0, 1, 1, 32'h200, 0, 0, 5'd9, 0);
    step(0, 1, 1, 32'h200, 0, 0, 5'd9, 0);
    idle(1, 0);
    wr(32'h0, 32'h0, 4'h0);
    idle(2, 0);
    step(1, 1, 1, 32'h10, 0, 0, 5'd5, 0);
    idle(2, 0);
    repeat (600) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      a = k == 0 ? 32'($urandom) : k == 1 ? {24'b0, 8'($urandom)} :
          ((32'($urandom_range(0, 3 + N)) << 2) | 32'($urandom_range(0, 3)));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 1'($urandom), a,
           32'($urandom), 4'($urandom), IW'($urandom), $urandom_range(0, 5) == 0);
    end
    idle(3, 0);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
